// File: rtl/lsu_if.sv
// Memory-side bus of the load/store unit: request, write strobe, lanes,
// grant and read-data return, with one modport per side.
interface lsu_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: decodes RV32 loads/stores, drives a req/gnt/rvalid bus,
// extracts and writes back load data, flags misalignment and bus timeouts.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ins_valid_i,
  input  logic [31:0] ins_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output logic        hold_flag_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_wr_en,
  output logic        misalign_o,
  output logic        bus_err_o,
  lsu_if.master       bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_addr, r_wdata, r_rd_data;
  logic [3:0]        r_be;
  logic [1:0]        r_size;
  logic              r_uns, r_we, r_rd_we, r_misalign, r_berr;
  logic [4:0]        r_rd, r_rd_addr;

  logic [6:0]        w_opcode;
  logic [2:0]        w_f3;
  logic              w_is_load, w_is_store, w_misal;
  logic signed [31:0] w_imm;
  logic [31:0]       w_addr, w_wdata;
  logic [3:0]        w_be;
  logic              w_accept, w_misalign, w_timeout, w_load_done, w_unused;

  function automatic logic [31:0] f_extract(input logic [31:0] rdata, input logic [1:0] off,
                                            input logic [1:0] size, input logic uns);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = rdata >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      2'b00:   f_extract = uns ? {24'b0, sh[7:0]}  : 32'(b);
      2'b01:   f_extract = uns ? {16'b0, sh[15:0]} : 32'(h);
      default: f_extract = sh;
    endcase
  endfunction

  assign w_opcode   = ins_i[6:0];
  assign w_f3       = ins_i[14:12];
  assign w_is_load  = (w_opcode == 7'b0000011) &&
                      (w_f3 == 3'b000 || w_f3 == 3'b001 || w_f3 == 3'b010 ||
                       w_f3 == 3'b100 || w_f3 == 3'b101);
  assign w_is_store = (w_opcode == 7'b0100011) && !w_f3[2] && (w_f3[1:0] != 2'b11);
  assign w_imm      = w_is_store ? {{20{ins_i[31]}}, ins_i[31:25], ins_i[11:7]}
                                 : {{20{ins_i[31]}}, ins_i[31:20]};
  assign w_addr     = rs1_data_i + $unsigned(w_imm);
  assign w_misal    = (w_f3[1:0] == 2'b01 && w_addr[0]) ||
                      (w_f3[1:0] == 2'b10 && w_addr[1:0] != 2'b00);
  assign w_unused   = ^ins_i[19:15];

  // Byte enables follow the access size for loads and stores alike.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'b0;
    case (w_f3[1:0])
      2'b00:   w_be = 4'b0001 << w_addr[1:0];
      2'b01:   w_be = 4'b0011 << w_addr[1:0];
      default: w_be = 4'b1111;
    endcase
    if (w_is_store) begin
      case (w_f3[1:0])
        2'b00:   w_wdata = {4{rs2_data_i[7:0]}};
        2'b01:   w_wdata = {2{rs2_data_i[15:0]}};
        default: w_wdata = rs2_data_i;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    hold_flag_o = 1'b0;
    w_accept    = 1'b0;
    w_misalign  = 1'b0;
    w_timeout   = 1'b0;
    w_load_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst && ins_valid_i && (w_is_load || w_is_store)) begin
          if (w_misal) begin
            w_misalign = 1'b1;
          end else begin
            w_accept    = 1'b1;
            hold_flag_o = 1'b1;
            w_state_nxt = REQ;
          end
        end
      end
      REQ: begin
        hold_flag_o = 1'b1;
        if (bus.mem_gnt_i) begin
          w_state_nxt = r_we ? IDLE : WAIT;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        hold_flag_o = 1'b1;
        if (bus.mem_rvalid_i) begin
          w_load_done = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bus outputs are only live while requesting, so they read zero at all other times.
  assign bus.mem_req_o   = (r_state == REQ);
  assign bus.mem_we_o    = (r_state == REQ) && r_we;
  assign bus.mem_addr_o  = (r_state == REQ) ? {r_addr[31:2], 2'b00} : 32'b0;
  assign bus.mem_wdata_o = (r_state == REQ) ? r_wdata : 32'b0;
  assign bus.mem_be_o    = (r_state == REQ) ? r_be : 4'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_size     <= '0;
      r_uns      <= 1'b0;
      r_we       <= 1'b0;
      r_rd       <= '0;
      r_rd_we    <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_data  <= '0;
      r_misalign <= 1'b0;
      r_berr     <= 1'b0;
    end else begin
      r_misalign <= w_misalign;
      r_berr     <= w_timeout;
      r_rd_we    <= w_load_done && (r_rd != 5'd0);
      if (w_accept) begin
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
        r_be    <= w_be;
        r_size  <= w_f3[1:0];
        r_uns   <= w_f3[2];
        r_we    <= w_is_store;
        r_rd    <= ins_i[11:7];
      end
      if (w_load_done && (r_rd != 5'd0)) begin
        r_rd_addr <= r_rd;
        r_rd_data <= f_extract(bus.mem_rdata_i, r_addr[1:0], r_size, r_uns);
      end
      if (w_accept || (r_state == REQ && bus.mem_gnt_i)) r_cnt <= '0;
      else if (r_state != IDLE)                         r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign rd_wr_en   = r_rd_we;
  assign rd_addr_o  = r_rd_addr;
  assign rd_data_o  = r_rd_data;
  assign misalign_o = r_misalign;
  assign bus_err_o  = r_berr;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus pushes expected bus grants, writebacks and
// exception pulses; a negedge monitor pops and compares each one the DUT presents.
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        ins_valid_i;
  logic [31:0] ins_i, rs1_data_i, rs2_data_i;
  logic        hold_flag_o, rd_wr_en, misalign_o, bus_err_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  lsu_if bus();

  lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ins_valid_i(ins_valid_i), .ins_i(ins_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .hold_flag_o(hold_flag_o),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_wr_en(rd_wr_en),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o), .bus(bus)
  );

  always #5 clk = ~clk;

  localparam int K_REQ = 0, K_WB = 1, K_MIS = 2, K_ERR = 3;
  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        we;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic push(input int k, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic we);
    ev_t e;
    e.kind = k; e.a = a; e.d = d; e.be = be; e.we = we;
    exp_q.push_back(e);
  endtask

  task automatic got(input int k, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic we);
    ev_t e;
    bit  ok;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d a=%h d=%h be=%b we=%b, required none", k, a, d, be, we);
    end else begin
      e  = exp_q.pop_front();
      ok = (e.kind == k) && (e.a == a) && (e.be == be) && (e.we == we);
      if (!(k == K_REQ && !we)) ok = ok && (e.d == d);
      if (!ok) begin
        n_fail++;
        $display("FAIL event: got kind=%0d a=%h d=%h be=%b we=%b, required kind=%0d a=%h d=%h be=%b we=%b",
                 k, a, d, be, we, e.kind, e.a, e.d, e.be, e.we);
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_req_o && bus.mem_gnt_i)
      got(K_REQ, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o, bus.mem_we_o);
    if (rd_wr_en)   got(K_WB, {27'b0, rd_addr_o}, rd_data_o, 4'b0, 1'b0);
    if (misalign_o) got(K_MIS, 32'b0, 32'b0, 4'b0, 1'b0);
    if (bus_err_o)  got(K_ERR, 32'b0, 32'b0, 4'b0, 1'b0);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_ld(input logic [2:0] f3, input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd1, f3, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_st(input logic [2:0] f3, input logic [11:0] imm);
    return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'b0100011};
  endfunction

  task automatic issue(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2);
    ins_i = ins; rs1_data_i = rs1; rs2_data_i = rs2; ins_valid_i = 1'b1;
    #1;
  endtask

  task automatic access(input string nm, input logic [31:0] ins, input logic [31:0] rs1,
                        input logic [31:0] rs2, input int gdly, input bit is_ld,
                        input int rdly, input logic [31:0] rdata);
    issue(ins, rs1, rs2);
    chk({nm, "_hold_accept"}, hold_flag_o, 1);
    tick();
    ins_valid_i = 1'b0;
    for (int i = 0; i < gdly; i++) begin
      chk({nm, "_hold_req"}, hold_flag_o, 1);
      chk({nm, "_req"}, bus.mem_req_o, 1);
      tick();
    end
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i = 1'b0;
    if (is_ld) begin
      for (int i = 0; i < rdly; i++) begin
        chk({nm, "_hold_wait"}, hold_flag_o, 1);
        tick();
      end
      bus.mem_rdata_i  = rdata;
      bus.mem_rvalid_i = 1'b1;
      tick();
      bus.mem_rvalid_i = 1'b0;
    end
    chk({nm, "_hold_idle"}, hold_flag_o, 0);
    tick();
    chk({nm, "_wr_en_single"}, rd_wr_en, 0);
  endtask

  task automatic misaligned(input string nm, input logic [31:0] ins, input logic [31:0] rs1);
    push(K_MIS, 32'b0, 32'b0, 4'b0, 1'b0);
    issue(ins, rs1, 32'h0);
    chk({nm, "_hold"}, hold_flag_o, 0);
    chk({nm, "_req"}, bus.mem_req_o, 0);
    tick();
    ins_valid_i = 1'b0;
    chk({nm, "_pulse"}, misalign_o, 1);
    chk({nm, "_req_after"}, bus.mem_req_o, 0);
    tick();
    chk({nm, "_pulse_end"}, misalign_o, 0);
  endtask

  task automatic ignored(input string nm, input logic [31:0] ins);
    issue(ins, 32'h100, 32'h5);
    chk({nm, "_hold"}, hold_flag_o, 0);
    tick();
    ins_valid_i = 1'b0;
    chk({nm, "_req"}, bus.mem_req_o, 0);
    tick();
  endtask

  function automatic logic [127:0] all_outs();
    return {hold_flag_o, rd_wr_en, misalign_o, bus_err_o, bus.mem_req_o, bus.mem_we_o,
            bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o, rd_addr_o, rd_data_o};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; ins_valid_i = 1'b0; ins_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    repeat (3) tick();
    chk("reset_outputs", all_outs(), 0);
    rst = 1'b0;
    tick();

    // Word load with delayed grant and data
    push(K_REQ, 32'h104, 32'h0, 4'b1111, 1'b0);
    push(K_WB, 32'd5, 32'hDEADBEEF, 4'b0, 1'b0);
    access("lw", enc_ld(3'b010, 5'd5, 12'd4), 32'h100, 32'h0, 2, 1'b1, 1, 32'hDEADBEEF);

    // Sub-word loads from rdata 0x80FF1234
    push(K_REQ, 32'h200, 32'h0, 4'b1000, 1'b0);
    push(K_WB, 32'd6, 32'hFFFFFF80, 4'b0, 1'b0);
    access("lb", enc_ld(3'b000, 5'd6, 12'd3), 32'h200, 32'h0, 1, 1'b1, 0, 32'h80FF1234);
    push(K_REQ, 32'h200, 32'h0, 4'b1000, 1'b0);
    push(K_WB, 32'd7, 32'h00000080, 4'b0, 1'b0);
    access("lbu", enc_ld(3'b100, 5'd7, 12'd3), 32'h200, 32'h0, 0, 1'b1, 0, 32'h80FF1234);
    push(K_REQ, 32'h200, 32'h0, 4'b1100, 1'b0);
    push(K_WB, 32'd10, 32'hFFFF80FF, 4'b0, 1'b0);
    access("lh", enc_ld(3'b001, 5'd10, 12'd2), 32'h200, 32'h0, 0, 1'b1, 2, 32'h80FF1234);
    push(K_REQ, 32'h200, 32'h0, 4'b0011, 1'b0);
    push(K_WB, 32'd11, 32'h00001234, 4'b0, 1'b0);
    access("lhu", enc_ld(3'b101, 5'd11, 12'd0), 32'h200, 32'h0, 0, 1'b1, 0, 32'h80FF1234);

    // Stores: lane replication and byte enables; SW uses a negative offset
    push(K_REQ, 32'h300, 32'hABCDABCD, 4'b1100, 1'b1);
    access("sh", enc_st(3'b001, 12'd2), 32'h300, 32'h0000ABCD, 0, 1'b0, 0, 32'h0);
    push(K_REQ, 32'h300, 32'h78787878, 4'b0010, 1'b1);
    access("sb", enc_st(3'b000, 12'd1), 32'h300, 32'h12345678, 1, 1'b0, 0, 32'h0);
    push(K_REQ, 32'h400, 32'hCAFEF00D, 4'b1111, 1'b1);
    access("sw", enc_st(3'b010, 12'hFF0), 32'h410, 32'hCAFEF00D, 0, 1'b0, 0, 32'h0);

    // Load to x0 still goes on the bus but never writes back
    push(K_REQ, 32'h500, 32'h0, 4'b1111, 1'b0);
    access("lw_x0", enc_ld(3'b010, 5'd0, 12'd0), 32'h500, 32'h0, 0, 1'b1, 0, 32'h55555555);

    misaligned("mis_lw", enc_ld(3'b010, 5'd4, 12'd1), 32'h100);
    misaligned("mis_sh", enc_st(3'b001, 12'd3), 32'h300);

    ignored("ign_addi", 32'h00000013);
    ignored("ign_ld_f3_011", enc_ld(3'b011, 5'd3, 12'd0));
    ignored("ign_st_f3_100", enc_st(3'b100, 12'd0));

    // Grant never arrives
    push(K_ERR, 32'b0, 32'b0, 4'b0, 1'b0);
    issue(enc_ld(3'b010, 5'd8, 12'd0), 32'h600, 32'h0);
    tick();
    ins_valid_i = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (!bus.mem_req_o) break;
      n++;
      tick();
    end
    chk("timeout_req_cycles", n, 4);
    chk("timeout_req_err", bus_err_o, 1);
    tick();
    chk("timeout_req_err_end", bus_err_o, 0);
    chk("timeout_req_hold", hold_flag_o, 0);

    // Grant but read data never arrives; the late rvalid afterwards is ignored
    push(K_REQ, 32'h604, 32'h0, 4'b1111, 1'b0);
    push(K_ERR, 32'b0, 32'b0, 4'b0, 1'b0);
    issue(enc_ld(3'b010, 5'd8, 12'd4), 32'h600, 32'h0);
    tick();
    ins_valid_i = 1'b0;
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (!hold_flag_o) break;
      n++;
      tick();
    end
    chk("timeout_wait_cycles", n, 4);
    bus.mem_rdata_i = 32'h77777777;
    bus.mem_rvalid_i = 1'b1;
    tick();
    bus.mem_rvalid_i = 1'b0;
    tick();
    chk("late_rvalid_no_wb", rd_wr_en, 0);

    // Reset while waiting for read data
    push(K_REQ, 32'h700, 32'h0, 4'b1111, 1'b0);
    issue(enc_ld(3'b010, 5'd9, 12'd0), 32'h700, 32'h0);
    tick();
    ins_valid_i = 1'b0;
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i = 1'b0;
    chk("wait_before_rst_hold", hold_flag_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mem_rdata_i = 32'h11111111;
    bus.mem_rvalid_i = 1'b1;
    tick();
    bus.mem_rvalid_i = 1'b0;
    chk("rst_wait_outputs", all_outs(), 0);
    tick();
    chk("rst_wait_no_wb", rd_wr_en, 0);

    repeat (2) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max wait cycles for mem_gnt_i or mem_rvalid_i before an access is aborted.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ins_valid_i  input  1  ins_i/operands valid this cycle.
REQ-005 ins_i  input  32  instruction word from execute stage.
REQ-006 rs1_data_i  input  32  base address operand.
REQ-007 rs2_data_i  input  32  store data operand.
REQ-008 hold_flag_o  output  1  stall request to upstream stages.
REQ-009 rd_addr_o, rd_data_o, rd_wr_en  output  5/32/1  load writeback port.
REQ-010 misalign_o, bus_err_o  output  1/1  one-cycle exception pulses.
REQ-011 mem_req_o, mem_we_o  output  1/1  bus request, write strobe.
REQ-012 mem_addr_o, mem_wdata_o  output  32/32  word-aligned address, lane-replicated write data.
REQ-013 mem_be_o  output  4  byte enables.
REQ-014 mem_gnt_i, mem_rvalid_i  input  1/1  request accepted, read data valid.
REQ-015 mem_rdata_i  input  32  read data word.

Function
REQ-016 The block SHALL decode loads (opcode 0000011: LB 000, LH 001, LW 010, LBU 100, LHU 101) and stores (opcode 0100011: SB 000, SH 001, SW 010); every other opcode/func3 SHALL be ignored with no output activity.
REQ-017 Effective address SHALL be rs1_data_i + sign-extended ins_i[31:20] (loads) or {ins_i[31:25],ins_i[11:7]} (stores), modulo 2^32.
REQ-018 FSM states SHALL be IDLE, REQ, WAIT.
REQ-019 In IDLE with ins_valid_i and an aligned valid access, the block SHALL capture address, size, sign, rd and store data, and enter REQ next cycle.
REQ-020 hold_flag_o SHALL be combinationally 1 in IDLE when accepting, 1 in REQ and WAIT, and 0 otherwise.
REQ-021 In REQ, mem_req_o SHALL be 1 with stable addr/we/be/wdata until mem_gnt_i; on grant a store SHALL return to IDLE, and a load SHALL enter WAIT.
REQ-022 In WAIT, on mem_rvalid_i the block SHALL return to IDLE and on the next cycle pulse rd_wr_en for exactly one cycle with extracted data.
REQ-023 mem_addr_o SHALL be {addr[31:2],2'b00}.
REQ-024 Store lanes: SB wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0]; SH wdata={2{rs2[15:0]}}, be=4'b0011<<addr[1:0]; SW wdata=rs2, be=4'b1111.
REQ-025 Load extraction SHALL select the byte/halfword at addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass through.
REQ-026 A load with rd=0 SHALL perform the bus access but SHALL keep rd_wr_en at 0.
REQ-027 Misalignment (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) SHALL produce no bus request, a one-cycle misalign_o pulse on the next cycle, and no state change from IDLE.
REQ-028 A wait counter SHALL clear on entry to REQ and on grant, and increment each cycle in REQ or WAIT; reaching TIMEOUT_CYCLES SHALL drop mem_req_o, return to IDLE, pulse bus_err_o one cycle, and suppress writeback.
REQ-029 mem_rvalid_i in IDLE or REQ SHALL be ignored.
REQ-030 ins_valid_i outside IDLE SHALL be ignored; upstream holds the instruction under hold_flag_o.

Reset
REQ-031 On rst, the state SHALL become IDLE and the counter 0. All outputs SHALL be 0: mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, rd_*, misalign_o, bus_err_o and hold_flag_o.
REQ-032 Reset mid-access SHALL abandon the access without writeback or error pulse; a subsequent late mem_rvalid_i SHALL be ignored.

Verification
REQ-033 LW rs1=0x100, imm=4, rd=5; gnt after 2 cycles, rvalid after 1 more with rdata=0xDEADBEEF -> mem_addr_o=0x104, be=1111, then rd_wr_en pulse with rd_addr_o=5, rd_data_o=0xDEADBEEF; hold_flag_o high throughout.
REQ-034 LB/LBU addr=0x203, rdata=0x80FF1234 -> rd_data_o=0xFFFFFF80 (LB), 0x00000080 (LBU).
REQ-035 SH addr=0x302, rs2=0x0000ABCD, immediate gnt -> mem_we_o=1, be=1100, wdata=0xABCDABCD, mem_addr_o=0x300, no rd_wr_en, IDLE next cycle.
REQ-036 LW addr=0x101 -> misalign_o one-cycle pulse, mem_req_o stays 0, hold_flag_o low after.
REQ-037 TIMEOUT_CYCLES=4, gnt never asserted -> mem_req_o drops after 4 cycles, bus_err_o one pulse, rd_wr_en stays 0.
REQ-038 rst asserted in WAIT, then rvalid -> all outputs 0, no writeback.
